// File: rtl/led_breathe.sv
// LED breathing controller: linear 8-bit brightness ramp up, hold, ramp down, hold,
// driving an active-low LED through a free-running 256-step PWM.
// Optional build macro LED_BREATHE_GAMMA_EN squares the level for a perceptual duty curve.
module led_breathe #(
  parameter int CLK_HZ     = 48000000,
  parameter int STEP_HZ    = 10000,
  parameter int HOLD_STEPS = 1024
) (
  input  logic       CLK_48,
  input  logic       RST_N,
  input  logic       EN,
  output logic       LED,
  output logic [7:0] PWM_DUTY,
  output logic [1:0] PHASE,
  output logic       CYCLE_DONE
);

  localparam int DIV    = CLK_HZ / STEP_HZ;
  localparam int DIV_W  = $clog2(DIV);
  localparam int HOLD_W = $clog2(HOLD_STEPS + 1);

  typedef enum logic [1:0] {
    RISE    = 2'd0,
    HOLD_HI = 2'd1,
    FALL    = 2'd2,
    HOLD_LO = 2'd3
  } phase_e;

  logic [DIV_W-1:0]  divCnt_q, divCnt_d;
  logic [7:0]        pwmCnt_q;
  logic [7:0]        level_q, level_d;
  phase_e            state_q, state_d;
  logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
  logic              cycleDone_q, cycleDone_d;
  logic [7:0]        duty_q;
  logic              led_q;
  logic              tick;
  logic [7:0]        target;

  // Prescaler: dropping EN parks it at zero so a resume always waits a full step.
  always_comb begin
    tick     = EN && (divCnt_q == DIV_W'(DIV - 1));
    divCnt_d = divCnt_q;
    if (!EN || tick) begin
      divCnt_d = '0;
    end else begin
      divCnt_d = divCnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    holdCnt_d   = holdCnt_q;
    cycleDone_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        RISE: begin
          if (level_q == 8'hFF) begin
            state_d   = HOLD_HI;
            holdCnt_d = '0;
          end else begin
            level_d = level_q + 8'd1;
          end
        end
        HOLD_HI: begin
          if (holdCnt_q == HOLD_W'(HOLD_STEPS - 1)) begin
            state_d   = FALL;
            holdCnt_d = '0;
          end else begin
            holdCnt_d = holdCnt_q + 1'b1;
          end
        end
        FALL: begin
          if (level_q == 8'h00) begin
            state_d   = HOLD_LO;
            holdCnt_d = '0;
          end else begin
            level_d = level_q - 8'd1;
          end
        end
        HOLD_LO: begin
          if (holdCnt_q == HOLD_W'(HOLD_STEPS - 1)) begin
            state_d     = RISE;
            holdCnt_d   = '0;
            cycleDone_d = 1'b1;
          end else begin
            holdCnt_d = holdCnt_q + 1'b1;
          end
        end
        default: state_d = RISE;
      endcase
    end
  end

`ifdef LED_BREATHE_GAMMA_EN
  assign target = 8'((16'(level_q) * 16'(level_q)) >> 8);
`else
  assign target = level_q;
`endif

  // Duty is latched only on the last PWM step so every period uses one constant value.
  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      divCnt_q    <= '0;
      pwmCnt_q    <= 8'd0;
      level_q     <= 8'd0;
      state_q     <= RISE;
      holdCnt_q   <= '0;
      cycleDone_q <= 1'b0;
      duty_q      <= 8'd0;
      led_q       <= 1'b1;
    end else begin
      divCnt_q    <= divCnt_d;
      pwmCnt_q    <= pwmCnt_q + 8'd1;
      level_q     <= level_d;
      state_q     <= state_d;
      holdCnt_q   <= holdCnt_d;
      cycleDone_q <= cycleDone_d;
      if (pwmCnt_q == 8'hFF) begin
        duty_q <= target;
      end
      led_q <= ~(EN & (pwmCnt_q < duty_q));
    end
  end

  assign LED        = led_q;
  assign PWM_DUTY   = duty_q;
  assign PHASE      = state_q;
  assign CYCLE_DONE = cycleDone_q;

endmodule

// File: tb/tb_led_breathe.sv
// Directed bench for led_breathe with CLK_HZ=1000, STEP_HZ=100, HOLD_STEPS=4
// (tick every 10 clocks, 520 ticks per breathe cycle); edges counted from reset release.
module tb_led_breathe;

  logic       CLK_48 = 1'b0;
  logic       RST_N;
  logic       EN;
  logic       LED;
  logic [7:0] PWM_DUTY;
  logic [1:0] PHASE;
  logic       CYCLE_DONE;

  int nVectors     = 0;
  int nMiscompares = 0;
  int edgeCnt      = 0;
  int relEdge      = 0;
  int doneCount    = 0;

  led_breathe #(
    .CLK_HZ    (1000),
    .STEP_HZ   (100),
    .HOLD_STEPS(4)
  ) dut (
    .CLK_48    (CLK_48),
    .RST_N     (RST_N),
    .EN        (EN),
    .LED       (LED),
    .PWM_DUTY  (PWM_DUTY),
    .PHASE     (PHASE),
    .CYCLE_DONE(CYCLE_DONE)
  );

  always #5 CLK_48 = ~CLK_48;

  always @(posedge CLK_48) edgeCnt <= edgeCnt + 1;

  always @(negedge CLK_48) if (CYCLE_DONE) doneCount <= doneCount + 1;

  // Reference duty for a given level in whichever build is compiled.
  function automatic int expDuty(input int lvl);
`ifdef LED_BREATHE_GAMMA_EN
    return (lvl * lvl) >> 8;
`else
    return lvl;
`endif
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nVectors++;
    if (observed != expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance to 1 time unit after edge number e (counted from reset release).
  task automatic applyStimulus(input int e);
    while (edgeCnt < relEdge + e) begin
      @(posedge CLK_48);
      #1;
    end
  endtask

  initial begin
    int lit;
    int bad;
    int badLed;
    int badPhase;

    RST_N = 1'b0;
    EN    = 1'b1;
    repeat (3) @(posedge CLK_48);
    #1;
    checkOutput("rst_led", LED, 1);
    checkOutput("rst_duty", PWM_DUTY, 0);
    checkOutput("rst_phase", PHASE, 0);
    checkOutput("rst_done", CYCLE_DONE, 0);

    @(negedge CLK_48);
    RST_N   = 1'b1;
    relEdge = edgeCnt;

    lit = 0;
    for (int e = 1; e <= 256; e++) begin
      applyStimulus(e);
      if (LED == 1'b0) lit++;
    end
    checkOutput("duty0_never_lit", lit, 0);
    checkOutput("duty_first_sample", PWM_DUTY, expDuty(25));

    applyStimulus(1279);
    checkOutput("duty_before_sample", PWM_DUTY, expDuty(102));
    applyStimulus(1280);
    checkOutput("duty_after_sample", PWM_DUTY, expDuty(127));
    lit = 0;
    bad = 0;
    for (int e = 1281; e <= 1536; e++) begin
      applyStimulus(e);
      if (LED == 1'b0) lit++;
      if (e <= 1535 && PWM_DUTY != 8'(expDuty(127))) bad++;
    end
    checkOutput("led_lit_mid", lit, expDuty(127));
    checkOutput("duty_stable_period", bad, 0);
    checkOutput("duty_next_sample", PWM_DUTY, expDuty(153));

    applyStimulus(2559);
    checkOutput("phase_rise_end", PHASE, 0);
    applyStimulus(2560);
    checkOutput("phase_hold_hi", PHASE, 1);
    checkOutput("duty_full", PWM_DUTY, expDuty(255));
    lit = 0;
    for (int e = 2561; e <= 2816; e++) begin
      applyStimulus(e);
      if (LED == 1'b0) lit++;
      if (e == 2599) checkOutput("phase_hold_hi_end", PHASE, 1);
      if (e == 2600) checkOutput("phase_fall", PHASE, 2);
    end
    checkOutput("led_lit_full", lit, expDuty(255));

    applyStimulus(5159);
    checkOutput("phase_fall_end", PHASE, 2);
    applyStimulus(5160);
    checkOutput("phase_hold_lo", PHASE, 3);
    applyStimulus(5199);
    checkOutput("phase_hold_lo_end", PHASE, 3);
    checkOutput("done_before_end", CYCLE_DONE, 0);
    checkOutput("done_count_before", doneCount, 0);
    applyStimulus(5200);
    checkOutput("done_pulse", CYCLE_DONE, 1);
    checkOutput("phase_wrap_rise", PHASE, 0);
    applyStimulus(5201);
    checkOutput("done_one_cycle", CYCLE_DONE, 0);
    checkOutput("done_count_after", doneCount, 1);

    applyStimulus(8003);
    checkOutput("phase_pre_freeze", PHASE, 2);
    EN = 1'b0;
    badLed   = 0;
    badPhase = 0;
    for (int e = 8004; e <= 9003; e++) begin
      applyStimulus(e);
      if (LED != 1'b1) badLed++;
      if (PHASE != 2'd2) badPhase++;
    end
    checkOutput("freeze_led_dark", badLed, 0);
    checkOutput("freeze_phase", badPhase, 0);
    checkOutput("freeze_no_done", doneCount, 1);
    checkOutput("freeze_level", PWM_DUTY, expDuty(235));
    EN = 1'b1;

    applyStimulus(11362);
    checkOutput("resume_fall_end", PHASE, 2);
    applyStimulus(11363);
    checkOutput("resume_hold_lo", PHASE, 3);
    applyStimulus(11402);
    checkOutput("resume_done_early", CYCLE_DONE, 0);
    applyStimulus(11403);
    checkOutput("resume_done_pulse", CYCLE_DONE, 1);
    checkOutput("resume_phase_rise", PHASE, 0);

    applyStimulus(13975);
    checkOutput("pre_reset_phase", PHASE, 1);
    checkOutput("pre_reset_duty", PWM_DUTY, expDuty(242));
    #2;
    RST_N = 1'b0;
    #1;
    checkOutput("async_rst_phase", PHASE, 0);
    checkOutput("async_rst_duty", PWM_DUTY, 0);
    checkOutput("async_rst_led", LED, 1);
    checkOutput("async_rst_done", CYCLE_DONE, 0);
    repeat (3) @(posedge CLK_48);
    @(negedge CLK_48);
    RST_N   = 1'b1;
    relEdge = edgeCnt;
    applyStimulus(255);
    checkOutput("restart_duty_zero", PWM_DUTY, 0);
    applyStimulus(256);
    checkOutput("restart_duty", PWM_DUTY, expDuty(25));
    checkOutput("restart_phase", PHASE, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
